chan_sel_bin_scheduler: RTL and testbench

Sequences the software-written channel-select bin registers into the channelizer datapath on user_clk.
- Holds a shadow copy of NUM_SLOTS bin words.
- Steps a slot counter aligned to the FFT frame sync and presents one bin index per cycle.
- Applies software updates only at frame boundaries, so a frame never mixes old and new bins.
- Sits between the PPC-to-Simulink bin registers (already in user_clk domain) and the channel-select mux.

---
 rtl/chan_sel_bin_scheduler_pkg.sv | 25 ++
 rtl/chan_sel_bin_scheduler_if.sv | 28 ++
 rtl/chan_sel_bin_scheduler_shadow_bank.sv | 58 +++++
 rtl/chan_sel_bin_scheduler.sv | 142 ++++++++++++++
 tb/tb_chan_sel_bin_scheduler.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/chan_sel_bin_scheduler_pkg.sv
// Shared definitions for the channel-select bin scheduler.
//   - FSM state encoding
//   - control register bit positions
//   - bin word enable bit
//   - status word field offsets
package chan_sel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  localparam int CTL_COMMIT = 0;
  localparam int CTL_RUN    = 1;

  localparam int BIN_EN_BIT = 31;

  localparam int STAT_COMMIT_LSB  = 0;
  localparam int STAT_RESYNC_LSB  = 8;
  localparam int STAT_PENDING_BIT = 16;
  localparam int STAT_RUNNING_BIT = 17;
  localparam int STAT_WAITING_BIT = 18;

endpackage

// File: rtl/chan_sel_bin_scheduler_if.sv
// Bus between the bin register block / FFT sync source and the scheduler.
//   master : drives cfg_bin_i, cfg_ctrl_i, sync_i; receives selection/status
//   slave  : the scheduler
interface chan_sel_bin_scheduler_if #(
  parameter int NUM_SLOTS = 4,
  parameter int BIN_W     = 8
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic [NUM_SLOTS*32-1:0] cfg_bin_i;
  logic [31:0]             cfg_ctrl_i;
  logic                    sync_i;
  logic [BIN_W-1:0]        sel_bin_o;
  logic [SLOT_W-1:0]       sel_slot_o;
  logic                    sel_valid_o;
  logic                    frame_start_o;
  logic [31:0]             status_o;

  modport master (
    output cfg_bin_i, cfg_ctrl_i, sync_i,
    input  sel_bin_o, sel_slot_o, sel_valid_o, frame_start_o, status_o
  );

  modport slave (
    input  cfg_bin_i, cfg_ctrl_i, sync_i,
    output sel_bin_o, sel_slot_o, sel_valid_o, frame_start_o, status_o
  );
endinterface

// File: rtl/chan_sel_bin_scheduler_shadow_bank.sv
// Shadow register bank: NUM_SLOTS entries of {enable, bin}.
//   user_clk, user_rst_n : clock, async active-low reset
//   i_load               : capture all words from i_words this cycle
//   i_words              : packed 32-bit bin words, word k at [32k+31:32k]
//   i_rd_slot            : slot to read
//   o_rd_bin, o_rd_en    : entry for i_rd_slot; shows the incoming word when
//                          i_load is high so the first slot of a freshly
//                          committed frame already uses the new values
module chan_sel_shadow_bank
  import chan_sel_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int BIN_W     = 8,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                    user_clk,
  input  logic                    user_rst_n,
  input  logic                    i_load,
  input  logic [NUM_SLOTS*32-1:0] i_words,
  input  logic [SLOT_W-1:0]       i_rd_slot,
  output logic [BIN_W-1:0]        o_rd_bin,
  output logic                    o_rd_en
);
  logic [BIN_W-1:0]     r_bin [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_en;
  logic [31:0]          w_word [NUM_SLOTS];
  logic                 w_unused_bits;

  always_comb begin
    w_unused_bits = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      w_word[k]     = i_words[32*k +: 32];
      w_unused_bits = w_unused_bits ^ (^w_word[k][30:BIN_W]);
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      for (int k = 0; k < NUM_SLOTS; k++) r_bin[k] <= '0;
      r_en <= '0;
    end else if (i_load) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        r_bin[k] <= w_word[k][BIN_W-1:0];
        r_en[k]  <= w_word[k][BIN_EN_BIT];
      end
    end
  end

  always_comb begin
    if (i_load) begin
      o_rd_bin = w_word[i_rd_slot][BIN_W-1:0];
      o_rd_en  = w_word[i_rd_slot][BIN_EN_BIT];
    end else begin
      o_rd_bin = r_bin[i_rd_slot];
      o_rd_en  = r_en[i_rd_slot];
    end
  end
endmodule

// File: rtl/chan_sel_bin_scheduler.sv
// Channel-select bin scheduler: steps through NUM_SLOTS shadow bin words in
// lock-step with the FFT frame sync and presents one bin index per cycle.
// Software bin updates (commit toggle) only take effect at frame boundaries.
//   user_clk, user_rst_n : clock, async active-low reset
//   cs_bus (slave)       : cfg_bin_i, cfg_ctrl_i, sync_i in;
//                          sel_bin_o, sel_slot_o, sel_valid_o,
//                          frame_start_o, status_o out (all registered)
//
// state        | meaning
// ST_IDLE      | run off; slot held at 0, pending commits load immediately
// ST_WAIT_SYNC | run on; waiting for the first frame sync
// ST_RUN       | presenting slots, wrapping every NUM_SLOTS cycles
module chan_sel_bin_scheduler
  import chan_sel_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int BIN_W     = 8
) (
  input logic                     user_clk,
  input logic                     user_rst_n,
  chan_sel_bin_scheduler_if.slave cs_bus
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  state_e            r_state, w_next_state;
  logic              r_ctl_q, r_pending;
  logic [7:0]        r_commit_cnt, r_resync_cnt;
  logic [SLOT_W-1:0] r_slot, w_next_slot;
  logic [BIN_W-1:0]  r_bin, w_rd_bin;
  logic              r_valid, r_frame_start, w_rd_en;
  logic              w_run, w_sync, w_commit_edge, w_pending_eff;
  logic              w_boundary, w_resync, w_load;
  logic [31:0]       w_status;
  logic              w_unused_ctl;

  assign w_run         = cs_bus.cfg_ctrl_i[CTL_RUN];
  assign w_sync        = cs_bus.sync_i;
  assign w_commit_edge = cs_bus.cfg_ctrl_i[CTL_COMMIT] ^ r_ctl_q;
  // An edge arriving on a boundary cycle is loaded on that same boundary.
  assign w_pending_eff = r_pending | w_commit_edge;
  assign w_load        = w_boundary & w_pending_eff;
  assign w_unused_ctl  = ^cs_bus.cfg_ctrl_i[31:2];

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) r_state <= ST_IDLE;
    else             r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:      if (w_run) w_next_state = ST_WAIT_SYNC;
      ST_WAIT_SYNC: if (!w_run) w_next_state = ST_IDLE;
                    else if (w_sync) w_next_state = ST_RUN;
      ST_RUN:       if (!w_run) w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  // Next slot and boundary decode. Leaving RUN is not a boundary: the
  // pending commit lands one cycle later from IDLE instead.
  always_comb begin
    w_next_slot = '0;
    w_boundary  = 1'b0;
    w_resync    = 1'b0;
    unique case (r_state)
      ST_IDLE:      w_boundary = 1'b1;
      ST_WAIT_SYNC: w_boundary = w_run & w_sync;
      ST_RUN: begin
        if (w_run) begin
          if (w_sync) begin
            w_boundary = 1'b1;
            w_resync   = (r_slot != LAST_SLOT);
          end else if (r_slot == LAST_SLOT) begin
            w_boundary = 1'b1;
          end else begin
            w_next_slot = r_slot + 1'b1;
          end
        end
      end
      default: w_boundary = 1'b0;
    endcase
  end

  chan_sel_shadow_bank #(
    .NUM_SLOTS (NUM_SLOTS),
    .BIN_W     (BIN_W),
    .SLOT_W    (SLOT_W)
  ) u_bank (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .i_load     (w_load),
    .i_words    (cs_bus.cfg_bin_i),
    .i_rd_slot  (w_next_slot),
    .o_rd_bin   (w_rd_bin),
    .o_rd_en    (w_rd_en)
  );

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_ctl_q      <= 1'b0;
      r_pending    <= 1'b0;
      r_commit_cnt <= '0;
      r_resync_cnt <= '0;
    end else begin
      r_ctl_q   <= cs_bus.cfg_ctrl_i[CTL_COMMIT];
      r_pending <= w_pending_eff & ~w_load;
      if (w_load) r_commit_cnt <= r_commit_cnt + 8'd1;
      if (w_resync && (r_resync_cnt != 8'hFF)) r_resync_cnt <= r_resync_cnt + 8'd1;
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_slot        <= '0;
      r_bin         <= '0;
      r_valid       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_slot        <= w_next_slot;
      r_bin         <= w_rd_bin;
      r_valid       <= (w_next_state == ST_RUN) && w_rd_en;
      r_frame_start <= (w_next_state == ST_RUN) && (w_next_slot == '0);
    end
  end

  always_comb begin
    w_status = '0;
    w_status[STAT_COMMIT_LSB +: 8] = r_commit_cnt;
    w_status[STAT_RESYNC_LSB +: 8] = r_resync_cnt;
    w_status[STAT_PENDING_BIT]     = r_pending;
    w_status[STAT_RUNNING_BIT]     = (r_state == ST_RUN);
    w_status[STAT_WAITING_BIT]     = (r_state == ST_WAIT_SYNC);
  end

  assign cs_bus.sel_bin_o     = r_bin;
  assign cs_bus.sel_slot_o    = r_slot;
  assign cs_bus.sel_valid_o   = r_valid;
  assign cs_bus.frame_start_o = r_frame_start;
  assign cs_bus.status_o      = w_status;
endmodule

// File: tb/tb_chan_sel_bin_scheduler.sv
// Bench for chan_sel_bin_scheduler: directed steps then random traffic,
// every cycle compared against a frame-level reference model.
module tb_chan_sel_bin_scheduler;
  localparam int NS = 4;
  localparam int BW = 8;
  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_RUN  = 2;

  logic user_clk   = 1'b0;
  logic user_rst_n = 1'b0;
  always #5 user_clk = ~user_clk;

  chan_sel_bin_scheduler_if #(.NUM_SLOTS(NS), .BIN_W(BW)) cs_bus ();

  chan_sel_bin_scheduler #(.NUM_SLOTS(NS), .BIN_W(BW)) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .cs_bus     (cs_bus)
  );

  logic [31:0] words [NS];
  logic [31:0] ctrl;
  logic        sync;

  always_comb begin
    cs_bus.cfg_bin_i = '0;
    for (int k = 0; k < NS; k++) cs_bus.cfg_bin_i[32*k +: 32] = words[k];
  end
  assign cs_bus.cfg_ctrl_i = ctrl;
  assign cs_bus.sync_i     = sync;

  int checks   = 0;
  int failures = 0;

  // Reference model: software-visible state of the scheduler.
  int          m_mode, m_slot, m_commit, m_resync;
  bit          m_pend, m_ctl;
  logic [BW-1:0] m_bin [NS];
  bit          m_en  [NS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {13'b0, 1'(m_mode == M_WAIT), 1'(m_mode == M_RUN), 1'(m_pend),
            8'(m_resync), 8'(m_commit)};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_slot = 0; m_commit = 0; m_resync = 0;
    m_pend = 0; m_ctl = 0;
    for (int k = 0; k < NS; k++) begin m_bin[k] = '0; m_en[k] = 0; end
  endtask

  // One clock of the frame rules, using the inputs present at the edge.
  task automatic model_step();
    bit edge_seen, run, boundary, resync;
    int next_mode, next_slot;
    edge_seen = (ctrl[0] != m_ctl);
    m_ctl     = ctrl[0];
    if (edge_seen) m_pend = 1;
    run = ctrl[1];
    boundary = 0; resync = 0; next_mode = m_mode; next_slot = 0;
    if (m_mode == M_IDLE) begin
      boundary = 1;
      if (run) next_mode = M_WAIT;
    end else if (!run) begin
      next_mode = M_IDLE;
    end else if (m_mode == M_WAIT) begin
      if (sync) begin next_mode = M_RUN; boundary = 1; end
    end else begin
      if (sync) begin boundary = 1; resync = (m_slot != NS - 1); end
      else if (m_slot == NS - 1) boundary = 1;
      else next_slot = m_slot + 1;
    end
    if (boundary && m_pend) begin
      for (int k = 0; k < NS; k++) begin
        m_bin[k] = words[k][BW-1:0];
        m_en[k]  = words[k][31];
      end
      m_commit = (m_commit + 1) % 256;
      m_pend   = 0;
    end
    if (resync && m_resync < 255) m_resync++;
    m_mode = next_mode;
    m_slot = next_slot;
  endtask

  task automatic check_all();
    chk("slot",        32'(cs_bus.sel_slot_o),    32'(m_slot));
    chk("bin",         32'(cs_bus.sel_bin_o),     32'(m_bin[m_slot]));
    chk("valid",       32'(cs_bus.sel_valid_o),   32'(m_mode == M_RUN && m_en[m_slot]));
    chk("frame_start", 32'(cs_bus.frame_start_o), 32'(m_mode == M_RUN && m_slot == 0));
    chk("status",      cs_bus.status_o,           exp_status());
  endtask

  task automatic cyc();
    @(posedge user_clk);
    model_step();
    @(negedge user_clk);
    check_all();
  endtask

  task automatic wait_slot(input int target);
    for (int i = 0; i < 2 * NS + 2; i++) begin
      if (m_mode == M_RUN && m_slot == target) break;
      cyc();
    end
    chk("wait_slot", 32'(cs_bus.sel_slot_o), 32'(target));
  endtask

  task automatic set_words(input int b0, input int b1, input int b2, input int b3, input bit en3);
    words[0] = {1'b1, 23'd0, 8'(b0)};
    words[1] = {1'b1, 23'd0, 8'(b1)};
    words[2] = {1'b1, 23'd0, 8'(b2)};
    words[3] = {en3,  23'd0, 8'(b3)};
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_bin"},    32'(cs_bus.sel_bin_o),     32'd0);
    chk({tag, "_slot"},   32'(cs_bus.sel_slot_o),    32'd0);
    chk({tag, "_valid"},  32'(cs_bus.sel_valid_o),   32'd0);
    chk({tag, "_fs"},     32'(cs_bus.frame_start_o), 32'd0);
    chk({tag, "_status"}, cs_bus.status_o,           32'd0);
  endtask

  int seq0 [NS] = '{5, 9, 200, 17};
  int seq1 [NS] = '{1, 2, 3, 4};

  initial begin
    for (int k = 0; k < NS; k++) words[k] = '0;
    ctrl = '0; sync = 0;
    model_reset();
    repeat (3) @(negedge user_clk);
    check_zero_outputs("reset");
    user_rst_n = 1'b1;
    cyc();

    // Commit in IDLE
    set_words(5, 9, 200, 17, 1'b1);
    ctrl[0] = ~ctrl[0];
    cyc();
    chk("commit_idle_cnt", 32'(cs_bus.status_o[7:0]), 32'd1);
    chk("commit_idle_pend", 32'(cs_bus.status_o[16]), 32'd0);

    // Run without sync: waits forever
    ctrl[1] = 1'b1;
    repeat (6) cyc();
    chk("wait_flag", 32'(cs_bus.status_o[18]), 32'd1);
    chk("wait_valid", 32'(cs_bus.sel_valid_o), 32'd0);

    // First sync: slot 0 next cycle, then 1,2,3,0...
    sync = 1; cyc(); sync = 0;
    chk("sync_slot0", 32'(cs_bus.sel_slot_o), 32'd0);
    chk("sync_fs", 32'(cs_bus.frame_start_o), 32'd1);
    chk("sync_bin0", 32'(cs_bus.sel_bin_o), 32'd5);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("walk_slot", 32'(cs_bus.sel_slot_o), 32'(i % NS));
      chk("walk_bin", 32'(cs_bus.sel_bin_o), 32'(seq0[i % NS]));
    end

    // Commit mid-frame: lands at next slot 0
    wait_slot(1);
    set_words(1, 2, 3, 4, 1'b1);
    ctrl[0] = ~ctrl[0];
    cyc();
    chk("mid_bin2", 32'(cs_bus.sel_bin_o), 32'd200);
    chk("mid_pend2", 32'(cs_bus.status_o[16]), 32'd1);
    cyc();
    chk("mid_bin3", 32'(cs_bus.sel_bin_o), 32'd17);
    chk("mid_pend3", 32'(cs_bus.status_o[16]), 32'd1);
    for (int i = 0; i < NS; i++) begin
      cyc();
      chk("new_frame_bin", 32'(cs_bus.sel_bin_o), 32'(seq1[i]));
    end
    chk("new_frame_pend", 32'(cs_bus.status_o[16]), 32'd0);
    chk("new_frame_cnt", 32'(cs_bus.status_o[7:0]), 32'd2);

    // Aligned sync at the last slot is not a resync
    wait_slot(NS - 1);
    sync = 1; cyc(); sync = 0;
    chk("aligned_resync", 32'(cs_bus.status_o[15:8]), 32'd0);
    chk("aligned_fs", 32'(cs_bus.frame_start_o), 32'd1);

    // Misaligned sync, then saturation
    wait_slot(2);
    sync = 1; cyc();
    chk("resync_slot", 32'(cs_bus.sel_slot_o), 32'd0);
    chk("resync_fs", 32'(cs_bus.frame_start_o), 32'd1);
    chk("resync_cnt1", 32'(cs_bus.status_o[15:8]), 32'd1);
    repeat (300) cyc();
    sync = 0;
    chk("resync_sat", 32'(cs_bus.status_o[15:8]), 32'd255);

    // Slot 3 disabled
    set_words(11, 22, 33, 44, 1'b0);
    ctrl[0] = ~ctrl[0];
    repeat (6) cyc();
    wait_slot(3);
    chk("dis_valid3", 32'(cs_bus.sel_valid_o), 32'd0);
    cyc();
    chk("dis_valid0", 32'(cs_bus.sel_valid_o), 32'd1);

    // Run cleared mid-frame
    wait_slot(1);
    ctrl[1] = 1'b0;
    cyc();
    chk("stop_valid", 32'(cs_bus.sel_valid_o), 32'd0);
    chk("stop_state", 32'(cs_bus.status_o[18:17]), 32'd0);
    chk("stop_slot", 32'(cs_bus.sel_slot_o), 32'd0);
    repeat (3) cyc();
    // run and sync together from IDLE: sync ignored
    ctrl[1] = 1'b1; sync = 1; cyc(); sync = 0;
    repeat (3) cyc();
    chk("rerun_wait", 32'(cs_bus.status_o[18]), 32'd1);
    chk("rerun_valid", 32'(cs_bus.sel_valid_o), 32'd0);
    sync = 1; cyc(); sync = 0;
    chk("rerun_fs", 32'(cs_bus.frame_start_o), 32'd1);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      sync = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) begin
        for (int k = 0; k < NS; k++) words[k] = $urandom;
        ctrl[0] = ~ctrl[0];
      end else if ($urandom_range(0, 4) == 0) begin
        words[$urandom_range(0, NS - 1)] = $urandom;
      end
      if ($urandom_range(0, 7) == 0) ctrl[31:2] = 30'($urandom);
      if ($urandom_range(0, 49) == 0) ctrl[1] = ~ctrl[1];
      cyc();
    end
    sync = 0;

    // Reset mid-frame with a commit pending
    ctrl[1] = 1'b1;
    repeat (2) cyc();
    sync = 1; cyc(); sync = 0;
    ctrl[0] = ~ctrl[0];
    words[0] = 32'h8000_00AA;
    cyc();
    chk("pre_rst_pend", 32'(cs_bus.status_o[16]), 32'd1);
    #2 user_rst_n = 1'b0;
    #1 check_zero_outputs("async_rst");
    model_reset();
    ctrl = '0;
    @(negedge user_clk);
    @(negedge user_clk);
    user_rst_n = 1'b1;
    repeat (3) cyc();
    chk("post_rst_cnt", 32'(cs_bus.status_o[7:0]), 32'd0);
    chk("post_rst_pend", 32'(cs_bus.status_o[16]), 32'd0);
    chk("post_rst_state", 32'(cs_bus.status_o[18:17]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
